alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU32 between two requesters, e.g. the integer issue port and the address-generation port.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates, registers operands into the ALU, captures the ALU result and returns it to the granted requester.
- One operation in flight at a time.

---
 rtl/alu_share_arbiter_if.sv | 29 ++
 rtl/alu_share_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response channels between two requesters and the shared-ALU arbiter.
// Requester i occupies bit i of each 2-bit vector and lane i of each packed bus.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OPWIDTH    = 6
);

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*OPWIDTH-1:0]    req_op;
  logic [2*DATA_WIDTH-1:0] req_a;
  logic [2*DATA_WIDTH-1:0] req_b_reg;
  logic [2*DATA_WIDTH-1:0] req_b_imm;
  logic [1:0]              req_sel;
  logic [1:0]              rsp_valid;
  logic [1:0]              rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b_reg, req_b_imm, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b_reg, req_b_imm, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OPWIDTH    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_share_arbiter_if.slave    bus,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2_1,
  output logic [DATA_WIDTH-1:0] alu_in2_2,
  output logic [OPWIDTH-1:0]    alu_op,
  output logic                  alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    any_req_s;
  logic                    grant_s;
  logic                    grant_r;
  logic [1:0]              req_ready_s;
  logic [1:0]              rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_data_r;
  logic [DATA_WIDTH-1:0]   alu_in1_r;
  logic [DATA_WIDTH-1:0]   alu_in2_1_r;
  logic [DATA_WIDTH-1:0]   alu_in2_2_r;
  logic [OPWIDTH-1:0]      alu_op_r;
  logic                    alu_sel_r;
  logic                    busy_r;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                    last_r;
`endif

  function automatic logic [DATA_WIDTH-1:0] lane_data(
    input logic [2*DATA_WIDTH-1:0] packed_v,
    input logic                    lane
  );
    if (lane) begin
      return packed_v[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      return packed_v[DATA_WIDTH-1:0];
    end
  endfunction

  function automatic logic [OPWIDTH-1:0] lane_op(
    input logic [2*OPWIDTH-1:0] packed_v,
    input logic                 lane
  );
    if (lane) begin
      return packed_v[2*OPWIDTH-1:OPWIDTH];
    end else begin
      return packed_v[OPWIDTH-1:0];
    end
  endfunction

  function automatic logic [1:0] lane_onehot(input logic lane);
    if (lane) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

  // Grant selection among currently valid requesters
  always_comb begin
    any_req_s = |bus.req_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (bus.req_valid[0]) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
`else
    // Prefer the requester that did not finish last; fall back to the other one
    if (bus.req_valid[~last_r]) begin
      grant_s = ~last_r;
    end else begin
      grant_s = last_r;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready[grant_r]) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: acceptance is combinational and forced low while reset is held
  always_comb begin
    req_ready_s = 2'b00;
    if (rst_n && (state_r == ST_IDLE) && any_req_s) begin
      req_ready_s = lane_onehot(grant_s);
    end else begin
      req_ready_s = 2'b00;
    end
  end

  // Grant, response and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r     <= 1'b0;
      rsp_valid_r <= 2'b00;
      rsp_data_r  <= {DATA_WIDTH{1'b0}};
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_r      <= 1'b1;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant_r <= grant_s;
          end
        end
        ST_EXEC: begin
          rsp_data_r  <= alu_out;
          rsp_valid_r <= lane_onehot(grant_r);
        end
        ST_RESP: begin
          if (bus.rsp_ready[grant_r]) begin
            rsp_valid_r <= 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_r      <= grant_r;
`endif
          end
        end
        default: begin
          rsp_valid_r <= 2'b00;
        end
      endcase
    end
  end

  // ALU operand registers; they hold the last issued op between operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1_r   <= {DATA_WIDTH{1'b0}};
      alu_in2_1_r <= {DATA_WIDTH{1'b0}};
      alu_in2_2_r <= {DATA_WIDTH{1'b0}};
      alu_op_r    <= {OPWIDTH{1'b0}};
      alu_sel_r   <= 1'b0;
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      alu_in1_r   <= lane_data(bus.req_a, grant_s);
      alu_in2_1_r <= lane_data(bus.req_b_reg, grant_s);
      alu_in2_2_r <= lane_data(bus.req_b_imm, grant_s);
      alu_op_r    <= lane_op(bus.req_op, grant_s);
      alu_sel_r   <= bus.req_sel[grant_s];
    end
  end

  // Busy flag registered from the next state so it tracks the FSM exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign alu_in1       = alu_in1_r;
  assign alu_in2_1     = alu_in2_1_r;
  assign alu_in2_2     = alu_in2_2_r;
  assign alu_op        = alu_op_r;
  assign alu_sel       = alu_sel_r;
  assign busy          = busy_r;

  alu_share_arbiter_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_ready (req_ready_s),
    .rsp_valid (rsp_valid_r),
    .busy      (busy_r)
  );

endmodule

// Handshake invariants of the arbiter.
module alu_share_arbiter_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] req_ready,
  input logic [1:0] rsp_valid,
  input logic       busy
);

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rsp_valid));

  a_no_ready_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> (req_ready == 2'b00));

  a_rsp_only_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid != 2'b00) |-> busy);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; the ALU itself is modelled here.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int OW = 6;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b100001;
  localparam logic [5:0] OP_SLT  = 6'b001001;
  localparam logic [5:0] OP_SLTU = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2_1;
  logic [DW-1:0] alu_in2_2;
  logic [OW-1:0] alu_op;
  logic          alu_sel;
  logic [DW-1:0] alu_out;
  logic          busy;
  logic [DW-1:0] alu_b;
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_WIDTH(DW), .OPWIDTH(OW)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPWIDTH(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_in1   (alu_in1),
    .alu_in2_1 (alu_in2_1),
    .alu_in2_2 (alu_in2_2),
    .alu_op    (alu_op),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .busy      (busy)
  );

  // Reference ALU: undecoded ops present a recognisable pattern
  always_comb begin
    alu_b   = alu_sel ? alu_in2_2 : alu_in2_1;
    alu_out = 32'hDEAD_BEEF;
    case (alu_op)
      OP_ADD:  alu_out = alu_in1 + alu_b;
      OP_SUB:  alu_out = alu_in1 - alu_b;
      OP_SLT:  alu_out = ($signed(alu_in1) < $signed(alu_b)) ? 32'd1 : 32'd0;
      OP_SLTU: alu_out = (alu_in1 < alu_b) ? 32'd1 : 32'd0;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b_reg, input logic [31:0] b_imm, input logic sel);
    bus.req_op[i*OW +: OW]    = op;
    bus.req_a[i*DW +: DW]     = a;
    bus.req_b_reg[i*DW +: DW] = b_reg;
    bus.req_b_imm[i*DW +: DW] = b_imm;
    bus.req_sel[i]            = sel;
  endtask

  // One isolated op from requester i, checked through every state
  task automatic run_op(input string tag, input int i, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b_reg,
                        input logic [31:0] b_imm, input logic sel, input logic [31:0] exp);
    logic [1:0] oh;
    oh = (i == 0) ? 2'b01 : 2'b10;
    set_req(i, op, a, b_reg, b_imm, sel);
    bus.req_valid = oh;
    #1;
    check({tag, "/ready"}, {30'd0, bus.req_ready}, {30'd0, oh});
    tick;
    bus.req_valid = 2'b00;
    #1;
    check({tag, "/exec_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "/exec_ready"}, {30'd0, bus.req_ready}, 32'd0);
    check({tag, "/exec_rspv"}, {30'd0, bus.rsp_valid}, 32'd0);
    tick;
    check({tag, "/rspv"}, {30'd0, bus.rsp_valid}, {30'd0, oh});
    check({tag, "/data"}, bus.rsp_data, exp);
    bus.rsp_ready = oh;
    tick;
    bus.rsp_ready = 2'b00;
    #1;
    check({tag, "/idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "/idle_rspv"}, {30'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0] oh;
    int         g;
    int         exp_g [3];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0};
`else
    exp_g = '{0, 1, 0};
`endif
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b_reg = '0;
    bus.req_b_imm = '0;
    bus.req_sel   = 2'b00;
    bus.rsp_ready = 2'b00;
    #2;
    check("rst_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rst_rspv", {30'd0, bus.rsp_valid}, 32'd0);
    check("rst_data", bus.rsp_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in1", alu_in1, 32'd0);
    check("rst_in2_2", alu_in2_2, 32'd0);
    check("rst_op", {26'd0, alu_op}, 32'd0);
    check("rst_sel", {31'd0, alu_sel}, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    #1;

    run_op("add0", 0, OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 32'd12);
    check("hold_in1", alu_in1, 32'd5);
    check("hold_in2_1", alu_in2_1, 32'd7);

    run_op("subimm1", 1, OP_SUB, 32'd10, 32'd3, 32'd4, 1'b1, 32'd6);
    check("subimm_sel", {31'd0, alu_sel}, 32'd1);
    check("subimm_in2_2", alu_in2_2, 32'd4);

    // Contention straight after reset
    rst_n = 1'b0;
    #1;
    tick;
    rst_n = 1'b1;
    #1;
    set_req(0, OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0);
    set_req(1, OP_ADD, 32'd2, 32'd2, 32'd0, 1'b0);
    bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 3; k++) begin
      g  = exp_g[k];
      oh = (g == 0) ? 2'b01 : 2'b10;
      check("cont_ready", {30'd0, bus.req_ready}, {30'd0, oh});
      tick;
      tick;
      check("cont_rspv", {30'd0, bus.rsp_valid}, {30'd0, oh});
      check("cont_data", bus.rsp_data, (g == 0) ? 32'd2 : 32'd4);
      bus.rsp_ready = oh;
      tick;
      bus.rsp_ready = 2'b00;
      #1;
    end
    bus.req_valid = 2'b00;
    #1;

    // Backpressure with the other requester waiting and pulsing its own rsp_ready
    set_req(0, OP_ADD, 32'd100, 32'd23, 32'd0, 1'b0);
    bus.req_valid = 2'b01;
    #1;
    check("bp_ready", {30'd0, bus.req_ready}, 32'd1);
    tick;
    set_req(1, OP_ADD, 32'd50, 32'd50, 32'd0, 1'b0);
    bus.req_valid = 2'b10;
    tick;
    bus.rsp_ready = 2'b10;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("bp_rspv", {30'd0, bus.rsp_valid}, 32'd1);
      check("bp_data", bus.rsp_data, 32'd123);
      check("bp_ready0", {30'd0, bus.req_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      tick;
    end
    bus.rsp_ready = 2'b01;
    tick;
    bus.rsp_ready = 2'b00;
    #1;
    check("bp_rel_busy", {31'd0, busy}, 32'd0);
    check("bp_rel_rspv", {30'd0, bus.rsp_valid}, 32'd0);
    check("bp_rel_ready", {30'd0, bus.req_ready}, 32'd2);
    bus.req_valid = 2'b00;
    tick;
    check("drop_busy", {31'd0, busy}, 32'd0);

    // Reset while the op is in EXEC
    set_req(1, OP_ADD, 32'd7, 32'd8, 32'd0, 1'b0);
    bus.req_valid = 2'b10;
    #1;
    check("rmid_ready", {30'd0, bus.req_ready}, 32'd2);
    tick;
    check("rmid_exec", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmid_rspv", {30'd0, bus.rsp_valid}, 32'd0);
    check("rmid_rdy", {30'd0, bus.req_ready}, 32'd0);
    check("rmid_busy", {31'd0, busy}, 32'd0);
    check("rmid_in1", alu_in1, 32'd0);
    tick;
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    #1;
    tick;
    check("rmid_norsp1", {30'd0, bus.rsp_valid}, 32'd0);
    tick;
    check("rmid_norsp2", {30'd0, bus.rsp_valid}, 32'd0);
    check("rmid_idle", {31'd0, busy}, 32'd0);
    set_req(0, OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0);
    set_req(1, OP_ADD, 32'd9, 32'd9, 32'd0, 1'b0);
    bus.req_valid = 2'b11;
    #1;
    check("rmid_grant0", {30'd0, bus.req_ready}, 32'd1);
    tick;
    bus.req_valid = 2'b00;
    tick;
    check("rmid_rspv0", {30'd0, bus.rsp_valid}, 32'd1);
    check("rmid_data", bus.rsp_data, 32'd7);
    bus.rsp_ready = 2'b01;
    tick;
    bus.rsp_ready = 2'b00;
    #1;

    // Signed versus unsigned compare, then an op the ALU does not decode
    run_op("slt", 0, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd1);
    run_op("sltu", 1, OP_SLTU, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 32'd0);
    run_op("badop", 0, OP_BAD, 32'd1, 32'd2, 32'd0, 1'b0, 32'hDEAD_BEEF);
    check("badop_pass", {26'd0, alu_op}, {26'd0, OP_BAD});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
